uart_tx_arbiter: RTL and testbench

Round-robin arbiter sharing a single `uart_tx` transmitter between up to `NUM_REQ` byte sources (echo path, status reporter, debug dump). Each requester presents bytes on a valid/ready handshake. The arbiter selects one requester, drives the transmitter's `start`/`data` pulse, and tracks `busy` until the frame completes. It sits between the top-level logic and the `uart_tx` instance (115200 baud, 25 MHz), replacing direct `tx_start` generation.

---
 rtl/uart_pkg.sv | 20 ++
 rtl/uart_tx_arbiter_rr_picker.sv | 34 +++
 rtl/uart_tx_arbiter.sv | 175 +++++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 342 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: arbiter state encoding and the system clock/baud
// constants also used by the uart_tx/uart_rx instances.
package uart_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE    = 2'd0,
    ARB_START   = 2'd1,
    ARB_WAIT_HI = 2'd2,
    ARB_WAIT_LO = 2'd3
  } uart_arb_state_t;

  localparam int UART_CLK_HZ = 25000000;
  localparam int UART_BAUD   = 115200;

  // Clock cycles per UART bit, rounded down.
  function automatic int uart_clks_per_bit(input int clk_hz, input int baud);
    return clk_hz / baud;
  endfunction

endpackage

// File: rtl/uart_tx_arbiter_rr_picker.sv
// Combinational round-robin picker: searches req starting one past ptr,
// wrapping modulo NUM_REQ, and returns a one-hot grant plus its index.
module rr_picker #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] gnt,
  output logic [IDX_W-1:0]   idx,
  output logic               any
);

  logic [IDX_W-1:0] cand;

  // First requester found after ptr (with wrap) wins; ptr itself is checked last.
  always_comb begin
    gnt  = '0;
    idx  = '0;
    any  = 1'b0;
    cand = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = IDX_W'((int'(ptr) + k) % NUM_REQ);
      if (!any && req[cand]) begin
        any       = 1'b1;
        gnt[cand] = 1'b1;
        idx       = cand;
      end else begin
        any = any;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one uart_tx between NUM_REQ byte sources.
// Optional feature macro: UART_ARB_LOCK_EN adds req_last and keeps a
// multi-byte message from one requester contiguous.
module uart_tx_arbiter #(
  parameter int NUM_REQ      = 4,
  parameter int DATA_W       = 8,
  parameter int BUSY_TIMEOUT = 4
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [NUM_REQ-1:0]          req_valid,
  input  logic [NUM_REQ*DATA_W-1:0]   req_data,
`ifdef UART_ARB_LOCK_EN
  input  logic [NUM_REQ-1:0]          req_last,
`endif
  output logic [NUM_REQ-1:0]          req_ready,
  output logic                        tx_start,
  output logic [DATA_W-1:0]           tx_data,
  input  logic                        tx_busy,
  output logic [$clog2(NUM_REQ)-1:0]  grant_id,
  output logic                        timeout_err
);
  import uart_pkg::*;

  localparam int IDX_W = $clog2(NUM_REQ);
  localparam int CNT_W = $clog2(BUSY_TIMEOUT + 1);

  uart_arb_state_t    state, state_next;
  logic [CNT_W-1:0]   cnt;
  logic [NUM_REQ-1:0] cand_req;
  logic [NUM_REQ-1:0] pick_gnt;
  logic [IDX_W-1:0]   pick_idx;
  logic               pick_any;
  logic [DATA_W-1:0]  sel_data;
  logic               accept;
  logic               hit_timeout;

`ifdef UART_ARB_LOCK_EN
  logic               locked;
  logic [NUM_REQ-1:0] lock_mask;

  // While locked only the last accepted requester may compete.
  always_comb begin
    lock_mask           = '0;
    lock_mask[grant_id] = 1'b1;
    if (locked) begin
      cand_req = req_valid & lock_mask;
    end else begin
      cand_req = req_valid;
    end
  end

  // Lock on a non-final byte, release on a final byte or a busy timeout.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      locked <= 1'b0;
    end else if (hit_timeout) begin
      locked <= 1'b0;
    end else if (accept) begin
      locked <= ~req_last[pick_idx];
    end else begin
      locked <= locked;
    end
  end
`else
  assign cand_req = req_valid;
`endif

  rr_picker #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_picker (
    .req (cand_req),
    .ptr (grant_id),
    .gnt (pick_gnt),
    .idx (pick_idx),
    .any (pick_any)
  );

  // Mux the winning requester's byte.
  always_comb begin
    sel_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (pick_gnt[i]) begin
        sel_data = req_data[i*DATA_W +: DATA_W];
      end else begin
        sel_data = sel_data;
      end
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ARB_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next state, grant and timeout detection; grants are suppressed while in reset.
  always_comb begin
    state_next  = state;
    req_ready   = '0;
    accept      = 1'b0;
    hit_timeout = 1'b0;
    case (state)
      ARB_IDLE: begin
        if (rst_n && !tx_busy && pick_any) begin
          req_ready  = pick_gnt;
          accept     = 1'b1;
          state_next = ARB_START;
        end else begin
          state_next = ARB_IDLE;
        end
      end
      ARB_START: begin
        state_next = ARB_WAIT_HI;
      end
      ARB_WAIT_HI: begin
        if (tx_busy) begin
          state_next = ARB_WAIT_LO;
        end else if (cnt == CNT_W'(BUSY_TIMEOUT - 1)) begin
          hit_timeout = 1'b1;
          state_next  = ARB_IDLE;
        end else begin
          state_next = ARB_WAIT_HI;
        end
      end
      ARB_WAIT_LO: begin
        if (!tx_busy) begin
          state_next = ARB_IDLE;
        end else begin
          state_next = ARB_WAIT_LO;
        end
      end
      default: begin
        state_next = ARB_IDLE;
      end
    endcase
  end

  // Registered transmitter interface, grant index, busy-wait counter and sticky error.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_start    <= 1'b0;
      tx_data     <= '0;
      grant_id    <= IDX_W'(NUM_REQ - 1);
      cnt         <= '0;
      timeout_err <= 1'b0;
    end else begin
      tx_start <= accept;
      if (accept) begin
        tx_data  <= sel_data;
        grant_id <= pick_idx;
      end else begin
        tx_data  <= tx_data;
        grant_id <= grant_id;
      end
      if (state == ARB_START) begin
        cnt <= '0;
      end else if (state == ARB_WAIT_HI) begin
        cnt <= cnt + CNT_W'(1);
      end else begin
        cnt <= cnt;
      end
      if (hit_timeout) begin
        timeout_err <= 1'b1;
      end else begin
        timeout_err <= timeout_err;
      end
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter: per-requester byte queues drive the
// DUT, a round-robin reference model predicts each grant, and a monitor
// compares every tx_start against the predicted byte and requester.
module tb_uart_tx_arbiter;
  localparam int NR = 4;
  localparam int DW = 8;
  localparam int TO = 4;

  typedef struct packed {
    logic [1:0] id;
    logic [7:0] data;
  } exp_t;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [NR-1:0]   req_valid;
  logic [NR*DW-1:0] req_data;
`ifdef UART_ARB_LOCK_EN
  logic [NR-1:0]   req_last;
`endif
  logic [NR-1:0]   req_ready;
  logic            tx_start;
  logic [DW-1:0]   tx_data;
  logic            tx_busy;
  logic [1:0]      grant_id;
  logic            timeout_err;

  logic stub_busy, ext_busy, stub_dead, stub_active, drop_en;

  logic [8:0] src_q [NR][$];
  exp_t       exp_q [$];
  int         glog [$];
  int         dlog [$];

  int   n_cmp = 0, n_err = 0, frames = 0, accepts = 0;
  int   model_ptr = NR - 1;
  logic model_locked = 1'b0;

  int         mon_w;
  logic [8:0] mon_ent;
  exp_t       mon_e;

  assign tx_busy = stub_busy | ext_busy;

  uart_tx_arbiter #(.NUM_REQ(NR), .DATA_W(DW), .BUSY_TIMEOUT(TO)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req_valid   (req_valid),
    .req_data    (req_data),
`ifdef UART_ARB_LOCK_EN
    .req_last    (req_last),
`endif
    .req_ready   (req_ready),
    .tx_start    (tx_start),
    .tx_data     (tx_data),
    .tx_busy     (tx_busy),
    .grant_id    (grant_id),
    .timeout_err (timeout_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: first valid requester after the last winner, wrapping; a lock restricts to the holder.
  function automatic int model_pick(input logic [NR-1:0] v);
    logic [NR-1:0] c;
    c = model_locked ? (v & (4'b0001 << model_ptr)) : v;
    for (int k = 1; k <= NR; k++) begin
      if (c[(model_ptr + k) % NR]) return (model_ptr + k) % NR;
    end
    return -1;
  endfunction

  function automatic bit busy_any();
    bit b;
    b = (exp_q.size() != 0) || stub_active || (tx_busy === 1'b1) || (tx_start === 1'b1);
    for (int i = 0; i < NR; i++) begin
      if (src_q[i].size() != 0) b = 1'b1;
    end
    return b;
  endfunction

  task automatic drain(input int bound);
    int n;
    n = 0;
    while (busy_any() && n < bound) begin
      @(negedge clk);
      n++;
    end
    check("drain_in_time", 32'(n < bound), 32'd1);
    repeat (3) @(negedge clk);
  endtask

  // Driver: present the head of each source queue, optionally dropping valid at random.
  initial begin
    req_valid = '0;
    req_data  = '0;
`ifdef UART_ARB_LOCK_EN
    req_last  = '0;
`endif
    forever begin
      @(posedge clk);
      #1;
      for (int i = 0; i < NR; i++) begin
        if (src_q[i].size() > 0 && (!drop_en || $urandom_range(0, 3) != 0)) begin
          req_valid[i]         = 1'b1;
          req_data[i*DW +: DW] = src_q[i][0][7:0];
`ifdef UART_ARB_LOCK_EN
          req_last[i]          = src_q[i][0][8];
`endif
        end else begin
          req_valid[i]         = 1'b0;
          req_data[i*DW +: DW] = '0;
`ifdef UART_ARB_LOCK_EN
          req_last[i]          = 1'b0;
`endif
        end
      end
    end
  end

  // uart_tx stub: busy rises 0..2 cycles after start and stays high 4..8 cycles.
  initial begin
    stub_busy   = 1'b0;
    stub_active = 1'b0;
    forever begin
      @(negedge clk);
      if (tx_start && !stub_dead) begin
        stub_active = 1'b1;
        @(posedge clk);
        repeat ($urandom_range(0, 2)) @(posedge clk);
        #1 stub_busy = 1'b1;
        repeat ($urandom_range(4, 8)) @(posedge clk);
        #1 stub_busy = 1'b0;
        stub_active = 1'b0;
      end
    end
  end

  // Monitor: predict each grant, queue the expected frame, compare on tx_start.
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (req_ready != '0) begin
          check("ready_onehot", 32'($onehot(req_ready)), 32'd1);
          check("ready_needs_valid", 32'(req_ready & ~req_valid), 32'd0);
          check("ready_while_busy", 32'(tx_busy), 32'd0);
          mon_w = model_pick(req_valid);
          if (mon_w < 0) begin
            check("ready_unexpected", 32'(req_ready), 32'd0);
          end else begin
            check("ready_winner", 32'(req_ready), 32'(4'b0001 << mon_w));
            mon_ent = src_q[mon_w].pop_front();
            exp_q.push_back({2'(mon_w), mon_ent[7:0]});
            model_ptr = mon_w;
`ifdef UART_ARB_LOCK_EN
            model_locked = ~mon_ent[8];
`endif
            accepts++;
          end
        end
        if (tx_start) begin
          frames++;
          if (exp_q.size() == 0) begin
            check("start_unexpected", 32'd1, 32'd0);
          end else begin
            mon_e = exp_q.pop_front();
            check("tx_data", 32'(tx_data), 32'(mon_e.data));
            check("grant_id", 32'(grant_id), 32'(mon_e.id));
          end
          glog.push_back(int'(grant_id));
          dlog.push_back(int'(tx_data));
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, f0, total;
    rst_n     = 1'b0;
    ext_busy  = 1'b0;
    stub_dead = 1'b0;
    drop_en   = 1'b0;

    // Reset state.
    repeat (3) @(negedge clk);
    check("rst_ready", 32'(req_ready), 32'd0);
    check("rst_tx_start", 32'(tx_start), 32'd0);
    check("rst_tx_data", 32'(tx_data), 32'd0);
    check("rst_grant_id", 32'(grant_id), 32'd3);
    check("rst_timeout_err", 32'(timeout_err), 32'd0);
    rst_n = 1'b1;

    // Fairness: all four valid with constant bytes, two each.
    @(negedge clk);
    glog.delete(); dlog.delete();
    for (int i = 0; i < NR; i++) begin
      src_q[i].push_back({1'b1, 8'h10 + 8'(i)});
      src_q[i].push_back({1'b1, 8'h10 + 8'(i)});
    end
    drain(400);
    check("fair_count", 32'(glog.size()), 32'd8);
    for (int j = 0; j < 8 && j < glog.size(); j++) begin
      check("fair_order", 32'(glog[j]), 32'(j % 4));
      check("fair_data", 32'(dlog[j]), 32'(8'h10 + 8'(j % 4)));
    end

    // Single byte from requester 2.
    f0 = frames;
    src_q[2].push_back({1'b1, 8'h41});
    n = 0;
    while (req_ready == '0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("single_ready_seen", 32'(n < 20), 32'd1);
    check("single_ready", 32'(req_ready), 32'h4);
    @(negedge clk);
    check("single_tx_start", 32'(tx_start), 32'd1);
    check("single_tx_data", 32'(tx_data), 32'h41);
    check("single_grant_id", 32'(grant_id), 32'd2);
    drain(200);
    check("single_frames", 32'(frames - f0), 32'd1);

    // Transmitter busy while idle holds off the grant.
    ext_busy = 1'b1;
    src_q[1].push_back({1'b1, 8'h5A});
    f0 = accepts;
    repeat (6) @(negedge clk);
    check("busy_hold", 32'(accepts - f0), 32'd0);
    @(posedge clk);
    #1 ext_busy = 1'b0;
    @(negedge clk);
    check("busy_release_grant", 32'(req_ready), 32'h2);
    drain(200);

    // Busy never rises: sticky timeout, then the next request is still served.
    stub_dead = 1'b1;
    src_q[2].push_back({1'b1, 8'h99});
    n = 0;
    while (tx_start !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("to_start_seen", 32'(n < 20), 32'd1);
    for (int k = 1; k <= TO + 1; k++) begin
      @(negedge clk);
      if (k == TO) check("to_not_yet", 32'(timeout_err), 32'd0);
      if (k == TO + 1) check("to_set", 32'(timeout_err), 32'd1);
    end
    stub_dead = 1'b0;
    f0 = frames;
    src_q[0].push_back({1'b1, 8'h77});
    drain(200);
    check("to_next_served", 32'(frames - f0), 32'd1);
    check("to_sticky", 32'(timeout_err), 32'd1);

    // Reset during WAIT_LO; afterwards requester 0 beats 3.
    src_q[1].push_back({1'b1, 8'h55});
    n = 0;
    while (tx_busy !== 1'b1 && n < 30) begin
      @(negedge clk);
      n++;
    end
    check("rst_mid_busy_seen", 32'(n < 30), 32'd1);
    @(negedge clk);
    glog.delete(); dlog.delete();
    src_q[0].push_back({1'b1, 8'hA0});
    src_q[3].push_back({1'b1, 8'hA3});
    @(posedge clk);
    #2 rst_n = 1'b0;
    model_ptr    = NR - 1;
    model_locked = 1'b0;
    #1;
    check("mid_rst_ready", 32'(req_ready), 32'd0);
    check("mid_rst_tx_start", 32'(tx_start), 32'd0);
    check("mid_rst_tx_data", 32'(tx_data), 32'd0);
    check("mid_rst_grant_id", 32'(grant_id), 32'd3);
    check("mid_rst_timeout_err", 32'(timeout_err), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    drain(300);
    check("post_rst_count", 32'(glog.size()), 32'd2);
    if (glog.size() == 2) begin
      check("post_rst_first", 32'(glog[0]), 32'd0);
      check("post_rst_second", 32'(glog[1]), 32'd3);
    end

`ifdef UART_ARB_LOCK_EN
    // Lock keeps requester 1's two-byte message contiguous.
    src_q[0].push_back({1'b1, 8'h01});
    drain(200);
    glog.delete(); dlog.delete();
    src_q[1].push_back({1'b0, 8'h48});
    src_q[1].push_back({1'b1, 8'h49});
    src_q[0].push_back({1'b1, 8'h30});
    drain(300);
    check("lock_count", 32'(dlog.size()), 32'd3);
    if (dlog.size() == 3) begin
      check("lock_first", 32'(dlog[0]), 32'h48);
      check("lock_second", 32'(dlog[1]), 32'h49);
      check("lock_third", 32'(dlog[2]), 32'h30);
    end
`endif

    // Randomized traffic in two waves with random valid drops.
    drop_en = 1'b1;
    total   = 0;
    f0      = frames;
    for (int wave = 0; wave < 2; wave++) begin
      for (int i = 0; i < NR; i++) begin
        n = $urandom_range(1, 6);
        for (int j = 0; j < n; j++) begin
          src_q[i].push_back({(j == n - 1) ? 1'b1 : 1'($urandom_range(0, 1)), 8'($urandom_range(0, 255))});
        end
        total += n;
      end
      repeat (40) @(negedge clk);
    end
    drain(6000);
    check("random_frames", 32'(frames - f0), 32'(total));
    drop_en = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
